// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared types, defaults and helpers for regfile_sb     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int c_DW_DEFAULT = 32;
  localparam int c_AW_DEFAULT = 5;
  localparam int c_NR_DEFAULT = 2;

  // True when the address hits the hard-wired zero register.
  function automatic logic f_is_zero_reg(input logic [31:0] addr, input logic zero_en);
    return zero_en && (addr == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_sb_if : decode/writeback bus of the register file           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface regfile_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic              init_done;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;

  modport master (
    input  init_done, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush
  );

  modport slave (
    output init_done, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_scoreboard : pending-write busy bits with per-port masking  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW       = c_AW_DEFAULT,
  parameter int NR       = c_NR_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic            i_active,
  input  wire logic            i_flush,
  input  wire logic            i_iss_en,
  input  wire logic [AW-1:0]   i_iss_addr,
  input  wire logic            i_wr_en,
  input  wire logic [AW-1:0]   i_wr_addr,
  input  wire logic [NR*AW-1:0] i_rd_addr,
  output logic      [NR-1:0]   o_rd_busy
);

  localparam int c_DEPTH = 1 << AW;

  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_nxt;

  // Later assignments override earlier ones: flush > issue > writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en)
      w_busy_nxt[i_wr_addr] = 1'b0;
    if (i_iss_en && !f_is_zero_reg(32'(i_iss_addr), ZERO_REG != 0))
      w_busy_nxt[i_iss_addr] = 1'b1;
    if (i_flush)
      w_busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_busy <= '0;
    else if (i_active)
      r_busy <= w_busy_nxt;
  end

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_busy
      logic [AW-1:0] w_addr;
      assign w_addr = i_rd_addr[gi*AW +: AW];
      assign o_rd_busy[gi] = i_active & r_busy[w_addr]
                           & ~(i_wr_en & (i_wr_addr == w_addr));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_sb : multi-port register file with bypass, busy scoreboard  |
// |              and a post-reset clear sequencer                       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = c_DW_DEFAULT,
  parameter int AW       = c_AW_DEFAULT,
  parameter int NR       = c_NR_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  regfile_sb_if.slave bus
);

  localparam int             c_DEPTH = 1 << AW;
  localparam logic [AW-1:0]  c_LAST  = AW'(c_DEPTH - 1);

  state_t         r_state;
  logic [AW-1:0]  r_clr_cnt;
  logic           r_init_done;
  logic [DW-1:0]  r_mem [c_DEPTH];

  logic           w_ready;
  logic           w_wr_en;

  assign w_ready = (r_state == ST_READY);
  assign w_wr_en = w_ready & bus.wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == c_LAST) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer owns zeroing it.
  always_ff @(posedge clk) begin
    if (!w_ready)
      r_mem[r_clr_cnt] <= '0;
    else if (w_wr_en && !f_is_zero_reg(32'(bus.wr_addr), ZERO_REG != 0))
      r_mem[bus.wr_addr] <= bus.wr_data;
  end

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      assign w_addr = bus.rd_addr[gi*AW +: AW];
      always_comb begin
        w_data = r_mem[w_addr];
        if (w_wr_en && (bus.wr_addr == w_addr))
          w_data = bus.wr_data;
        if (f_is_zero_reg(32'(w_addr), ZERO_REG != 0) || !w_ready)
          w_data = '0;
      end
      assign bus.rd_data[gi*DW +: DW] = w_data;
    end
  endgenerate

  regfile_scoreboard #(
    .AW       (AW),
    .NR       (NR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_active   (w_ready),
    .i_flush    (bus.flush),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_rd_addr  (bus.rd_addr),
    .o_rd_busy  (bus.rd_busy)
  );

  assign bus.init_done = r_init_done;

endmodule
`default_nettype wire
